nmp_bram_arbiter: RTL and testbench

- Shares one single-port BRAM between NREQ requesters, e.g. the AXI-lite command engine and the vector-add sequencer.
- Arbitration is round-robin. It grants one access per cycle and registers the RAM command. Read data returns to the granted requester with a fixed latency.
- A per-requester lock lets one master run an atomic burst (read A, read B, write R). A lock-length limit bounds starvation.

---
 rtl/nmp_pkg.sv | 15 +
 rtl/nmp_rr_pick.sv | 36 +++
 rtl/nmp_bram_arbiter.sv | 143 ++++++++++++++
 tb/tb_nmp_bram_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nmp_pkg.sv
// Shared constants for the NMP BRAM datapath: memory geometry, arbiter states, requester slots.
// No logic; imported by the arbiter and its picker.
// Backpressure: not applicable.
package nmp_pkg;

    localparam int NMP_RAM_WIDTH     = 32;
    localparam int NMP_RAM_ADDR_BITS = 12;

    localparam logic [0:0] ARB_UNLOCKED = 1'b0;
    localparam logic [0:0] ARB_LOCKED   = 1'b1;

    localparam int REQ_AXIL = 0;
    localparam int REQ_VEC  = 1;

endpackage

// File: rtl/nmp_rr_pick.sv
// Round-robin picker: first set request strictly after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; any=0 when no request is set.
module nmp_rr_pick #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [PW:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 1; i <= N; i++) begin
            // one spare bit so ptr+i never overflows before the explicit wrap
            cand = {1'b0, ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(N)) begin
                cand = cand - (PW+1)'(N);
            end
            if (!any && req[cand[PW-1:0]]) begin
                any              = 1'b1;
                idx              = cand[PW-1:0];
                gnt[cand[PW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nmp_bram_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between NREQ requesters, with per-requester lock.
// Latency: RAM command registered 1 cycle after accept; read response pulse 2 cycles after accept.
// Backpressure: one-hot ready per cycle; a lock owner stalls everyone else; responses cannot be stalled.
module nmp_bram_arbiter
    import nmp_pkg::*;
#(
    parameter int NREQ          = 2,
    parameter int RAM_WIDTH     = NMP_RAM_WIDTH,
    parameter int RAM_ADDR_BITS = NMP_RAM_ADDR_BITS,
    parameter int LOCK_LIMIT    = 16
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic [NREQ-1:0]               i_req_valid,
    output logic [NREQ-1:0]               o_req_ready,
    input  logic [NREQ-1:0]               i_req_we,
    input  logic [NREQ-1:0]               i_req_lock,
    input  logic [NREQ*RAM_ADDR_BITS-1:0] i_req_addr,
    input  logic [NREQ*RAM_WIDTH-1:0]     i_req_wdata,
    output logic [NREQ-1:0]               o_rsp_valid,
    output logic [RAM_WIDTH-1:0]          o_rsp_data,
    output logic                          o_ram_enable,
    output logic                          o_ram_we,
    output logic [RAM_ADDR_BITS-1:0]      o_ram_addr,
    output logic [RAM_WIDTH-1:0]          o_ram_wdata,
    input  logic [RAM_WIDTH-1:0]          i_ram_rdata
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = (LOCK_LIMIT > 0) ? $clog2(LOCK_LIMIT + 1) : 1;

    logic [0:0]      state;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   lock_cnt;
    logic [CW-1:0]   cnt_inc;
    logic            limit_hit;

    logic [NREQ-1:0] rr_gnt;
    logic [PW-1:0]   rr_idx;
    logic            rr_any;
    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gnt_idx;
    logic            acc_vld;
    logic [NREQ-1:0] rd_pend;

    logic [RAM_ADDR_BITS-1:0] addr_arr  [NREQ];
    logic [RAM_WIDTH-1:0]     wdata_arr [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign addr_arr[k]  = i_req_addr[k*RAM_ADDR_BITS +: RAM_ADDR_BITS];
        assign wdata_arr[k] = i_req_wdata[k*RAM_WIDTH +: RAM_WIDTH];
    end

    nmp_rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .req (i_req_valid),
        .ptr (ptr),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (rr_any)
    );

    // While locked, only the owner may be granted, even if it is idle.
    always_comb begin
        gnt     = '0;
        gnt_idx = rr_idx;
        acc_vld = 1'b0;
        if (state == ARB_LOCKED) begin
            gnt_idx = owner;
            if (i_req_valid[owner]) begin
                gnt[owner] = 1'b1;
                acc_vld    = 1'b1;
            end
        end else begin
            gnt     = rr_gnt;
            acc_vld = rr_any;
        end
    end

    assign o_req_ready = S_AXI_ARESETN ? gnt : '0;
    assign cnt_inc     = lock_cnt + CW'(1);
    assign limit_hit   = (LOCK_LIMIT != 0) && (cnt_inc == CW'(LOCK_LIMIT));

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state    <= ARB_UNLOCKED;
            owner    <= '0;
            ptr      <= PW'(NREQ - 1);
            lock_cnt <= '0;
        end else if (state == ARB_UNLOCKED) begin
            if (acc_vld) begin
                ptr <= gnt_idx;
                // a limit of one means the first locked access already exhausts the lock
                if (i_req_lock[gnt_idx] && (LOCK_LIMIT != 1)) begin
                    state    <= ARB_LOCKED;
                    owner    <= gnt_idx;
                    lock_cnt <= CW'(1);
                end
            end
        end else begin
            if (acc_vld) begin
                ptr <= owner;
                if (!i_req_lock[owner] || limit_hit) begin
                    state    <= ARB_UNLOCKED;
                    lock_cnt <= '0;
                end else if (LOCK_LIMIT != 0) begin
                    lock_cnt <= cnt_inc;
                end
            end else if (!i_req_valid[owner] && !i_req_lock[owner]) begin
                state    <= ARB_UNLOCKED;
                ptr      <= owner;
                lock_cnt <= '0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            o_ram_enable <= 1'b0;
            o_ram_we     <= 1'b0;
            o_ram_addr   <= '0;
            o_ram_wdata  <= '0;
            rd_pend      <= '0;
            o_rsp_valid  <= '0;
        end else begin
            o_ram_enable <= acc_vld;
            o_ram_we     <= acc_vld & i_req_we[gnt_idx];
            if (acc_vld) begin
                o_ram_addr  <= addr_arr[gnt_idx];
                o_ram_wdata <= wdata_arr[gnt_idx];
            end
            rd_pend     <= (acc_vld && !i_req_we[gnt_idx]) ? gnt : '0;
            o_rsp_valid <= rd_pend;
        end
    end

    // BRAM output register already aligns data with the response pulse.
    assign o_rsp_data = (|o_rsp_valid) ? i_ram_rdata : '0;

endmodule

// File: tb/tb_nmp_bram_arbiter.sv
// Directed + random bench for nmp_bram_arbiter against a rule-level reference model.
module tb_nmp_bram_arbiter;
    import nmp_pkg::*;

    localparam int NREQ = 2;
    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int LIM  = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      valid, we, lock;
    logic [NREQ*AW-1:0]   addr;
    logic [NREQ*DW-1:0]   wdata;
    logic [NREQ-1:0]      ready, rsp_valid;
    logic [DW-1:0]        rsp_data, ram_wdata, ram_rdata;
    logic                 ram_en, ram_we;
    logic [AW-1:0]        ram_addr;

    nmp_bram_arbiter #(
        .NREQ(NREQ), .RAM_WIDTH(DW), .RAM_ADDR_BITS(AW), .LOCK_LIMIT(LIM)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .i_req_valid(valid), .o_req_ready(ready), .i_req_we(we), .i_req_lock(lock),
        .i_req_addr(addr), .i_req_wdata(wdata),
        .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
        .o_ram_enable(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
        .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [AW-1:0] a);
        return (a == 12'h010) ? 32'hDEADBEEF : {8'hA5, 12'h000, a};
    endfunction

    // Single-port BRAM fixture with registered output.
    logic [31:0] ram [int];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram[int'(ram_addr)] = ram_wdata;
            else        ram_rdata <= ram.exists(int'(ram_addr)) ? ram[int'(ram_addr)] : init_word(ram_addr);
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] mdl_mem [int];
    bit          m_locked;
    int          m_owner, m_cnt, m_ptr;
    bit          c_en, c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic [NREQ-1:0] r_now, r_next;
    logic [DW-1:0]   d_now, d_next;
    logic [NREQ-1:0] rdy_log [$];
    logic [NREQ-1:0] obs_rsp_vld;
    logic [DW-1:0]   obs_rsp_dat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_cnt = 0; m_ptr = NREQ - 1;
        c_en = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        r_now = '0; r_next = '0; d_now = '0; d_next = '0;
    endtask

    function automatic logic [31:0] mdl_rd(input logic [AW-1:0] a);
        return mdl_mem.exists(int'(a)) ? mdl_mem[int'(a)] : init_word(a);
    endfunction

    task automatic set_req(input int k, input bit v, input bit w, input bit lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        valid[k] = v; we[k] = w; lock[k] = lk;
        addr[k*AW +: AW] = a; wdata[k*DW +: DW] = d;
    endtask

    task automatic idle();
        valid = '0; we = '0; lock = '0;
    endtask

    // One clock: predict grant, check outputs at negedge, advance model, return at posedge+1.
    task automatic step();
        int g;
        logic [NREQ-1:0] exp_rdy;
        g = -1;
        if (m_locked) begin
            if (valid[m_owner]) g = m_owner;
        end else begin
            for (int i = 1; i <= NREQ; i++) begin
                int c;
                c = (m_ptr + i) % NREQ;
                if (g < 0 && valid[c]) g = c;
            end
        end
        exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
        @(negedge clk);
        chk("ready", ready, exp_rdy);
        chk("ram_en", ram_en, c_en);
        chk("ram_we", ram_we, c_we);
        chk("ram_addr", ram_addr, c_addr);
        chk("ram_wdata", ram_wdata, c_wdata);
        chk("rsp_valid", rsp_valid, r_now);
        if (r_now != 0) chk("rsp_data", rsp_data, d_now);
        rdy_log.push_back(ready);
        obs_rsp_vld = rsp_valid;
        obs_rsp_dat = rsp_data;

        r_now = r_next; d_now = d_next; r_next = '0;
        if (g >= 0) begin
            c_en = 1; c_we = we[g];
            c_addr = addr[g*AW +: AW]; c_wdata = wdata[g*DW +: DW];
            if (we[g]) mdl_mem[int'(c_addr)] = c_wdata;
            else begin r_next = NREQ'(1 << g); d_next = mdl_rd(c_addr); end
            m_ptr = g;
            if (!m_locked) begin
                if (lock[g] && LIM != 1) begin m_locked = 1; m_owner = g; m_cnt = 1; end
            end else begin
                m_cnt++;
                if (!lock[g] || (LIM != 0 && m_cnt >= LIM)) begin m_locked = 0; m_cnt = 0; end
            end
        end else begin
            c_en = 0; c_we = 0;
            if (m_locked && !valid[m_owner] && !lock[m_owner]) begin
                m_locked = 0; m_cnt = 0; m_ptr = m_owner;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ready"}, ready, 0);
        chk({tag, " ram_en"}, ram_en, 0);
        chk({tag, " ram_we"}, ram_we, 0);
        chk({tag, " ram_addr"}, ram_addr, 0);
        chk({tag, " ram_wdata"}, ram_wdata, 0);
        chk({tag, " rsp_valid"}, rsp_valid, 0);
        chk({tag, " rsp_data"}, rsp_data, 0);
    endtask

    initial begin
        int b;
        rst_n = 1'b0; valid = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        model_reset();
        #12;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single read of preloaded word
        set_req(REQ_AXIL, 1, 0, 0, 12'h010, '0);
        b = rdy_log.size();
        step();
        idle();
        step();
        step();
        chk("t1 grant", rdy_log[b], 2'b01);
        chk("t1 rsp_valid", obs_rsp_vld, 2'b01);
        chk("t1 rsp_data", obs_rsp_dat, 32'hDEADBEEF);

        // Both requesters valid: strict alternation
        set_req(REQ_AXIL, 1, 0, 0, 12'h001, '0);
        set_req(REQ_VEC,  1, 0, 0, 12'h002, '0);
        b = rdy_log.size();
        for (int i = 0; i < 6; i++) step();
        for (int i = 0; i < 6; i++) chk("t2 alternate", rdy_log[b+i], (i % 2 == 0) ? 2'b10 : 2'b01);
        idle();
        step(); step();

        // Locked atomic burst by requester 1, requester 0 waiting on 0x300
        b = rdy_log.size();
        set_req(REQ_AXIL, 1, 0, 0, 12'h300, '0);
        set_req(REQ_VEC,  1, 0, 1, 12'h100, '0);
        step();
        set_req(REQ_VEC,  1, 0, 1, 12'h200, '0);
        step();
        set_req(REQ_VEC,  1, 1, 0, 12'h300, 32'h1234ABCD);
        step();
        set_req(REQ_VEC,  0, 0, 0, 12'h000, '0);
        step();
        idle();
        step(); step();
        chk("t3 lock g0", rdy_log[b],   2'b10);
        chk("t3 lock g1", rdy_log[b+1], 2'b10);
        chk("t3 lock g2", rdy_log[b+2], 2'b10);
        chk("t3 release", rdy_log[b+3], 2'b01);
        chk("t3 rsp_data", obs_rsp_dat, 32'h1234ABCD);
        chk("t3 ram_300", ram[12'h300], 32'h1234ABCD);

        // Lock limit: four grants to the owner, then the other requester
        set_req(REQ_VEC, 1, 0, 0, 12'h003, '0);
        step();
        b = rdy_log.size();
        set_req(REQ_AXIL, 1, 0, 1, 12'h007, '0);
        set_req(REQ_VEC,  1, 0, 0, 12'h008, '0);
        for (int i = 0; i < 5; i++) step();
        for (int i = 0; i < 4; i++) chk("t4 owner", rdy_log[b+i], 2'b01);
        chk("t4 forced", rdy_log[b+4], 2'b10);
        idle();
        step(); step(); step();

        // Write then read-after-write from the other requester
        set_req(REQ_VEC, 1, 1, 0, 12'h005, 32'hCAFE0001);
        step();
        idle();
        set_req(REQ_AXIL, 1, 0, 0, 12'h005, '0);
        step();
        idle();
        step();
        chk("t5 write no rsp", obs_rsp_vld, 2'b00);
        step();
        chk("t5 rsp_valid", obs_rsp_vld, 2'b01);
        chk("t5 rsp_data", obs_rsp_dat, 32'hCAFE0001);

        // Reset between a read accept and its response
        set_req(REQ_VEC, 1, 0, 0, 12'h010, '0);
        step();
        set_req(REQ_AXIL, 1, 0, 0, 12'h011, '0);
        set_req(REQ_VEC,  1, 0, 0, 12'h012, '0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        model_reset();
        @(posedge clk); #1;
        chk_all_zero("held reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        b = rdy_log.size();
        step(); step(); step();
        chk("t6 first grant", rdy_log[b], 2'b01);
        idle();
        step(); step();

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NREQ; k++) begin
                set_req(k, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                        $urandom_range(0, 3) == 0, AW'($urandom_range(0, 15)), $urandom);
            end
            step();
        end
        idle();
        for (int n = 0; n < 8; n++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
